// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: shares one registered output word among NUM_REQ
// sources. Ownership is held until the owner's last word is accepted, or until the
// owner stalls (valid low) for MAX_STALL consecutive locked cycles.
//
// state  | meaning
// IDLE   | no owner; arbitrate among req_valid starting at rr_ptr
// LOCKED | owner holds grant; words move into the output register
module rr_packet_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 2,
  parameter int MAX_STALL  = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_last,
  output logic [$clog2(NUM_REQ)-1:0]      out_src,
  input  logic                            out_ready,
  output logic                            timeout
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [PTR_W-1:0]      out_src_q, out_src_d;
  logic                  timeout_q, timeout_d;

  logic                  out_room;
  logic                  owner_valid;
  logic                  owner_last;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  transfer;
  logic [PTR_W-1:0]      winner;
  logic [PTR_W-1:0]      next_ptr;

  // Output slot can take a word when empty or being drained this cycle.
  assign out_room  = !out_valid_q || out_ready;
  // grant_q is zero outside LOCKED, so this also gives req_ready=0 in IDLE/reset.
  assign req_ready = grant_q & {NUM_REQ{out_room}};
  assign transfer  = (state_q == LOCKED) && owner_valid && out_room;
  assign next_ptr  = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

  // Select the current owner's request fields.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == PTR_W'(i)) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Rotating priority search; descending loop so the smallest offset from rr_ptr wins.
  always_comb begin
    logic [PTR_W:0] sum;
    winner = rr_ptr_q;
    sum    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      if (req_valid[sum[PTR_W-1:0]]) winner = sum[PTR_W-1:0];
    end
  end

  // Next-state logic for the FSM, output register, stall timer and pointer.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    stall_cnt_d = stall_cnt_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    timeout_d   = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = owner_data;
      out_last_d  = owner_last;
      out_src_d   = owner_q;
    end

    case (state_q)
      IDLE: begin
        stall_cnt_d = '0;
        if (|req_valid) begin
          state_d = LOCKED;
          owner_d = winner;
          grant_d = NUM_REQ'(1) << winner;
        end
      end
      LOCKED: begin
        if (transfer && owner_last) begin
          state_d     = IDLE;
          grant_d     = '0;
          rr_ptr_d    = next_ptr;
          stall_cnt_d = '0;
        end else if (owner_valid) begin
          stall_cnt_d = '0;
        end else if ((MAX_STALL > 0) && (stall_cnt_q == CNT_W'(MAX_STALL - 1))) begin
          // This cycle is the MAX_STALL-th stalled cycle: release the owner.
          state_d     = IDLE;
          grant_d     = '0;
          rr_ptr_d    = next_ptr;
          stall_cnt_d = '0;
          timeout_d   = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      stall_cnt_q <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      stall_cnt_q <= stall_cnt_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter (NUM_REQ=4, DATA_WIDTH=2, MAX_STALL=64).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rr_packet_arbiter;

  localparam int NR = 4;
  localparam int DW = 2;
  localparam int MS = 64;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    grant;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic [1:0]       out_src;
  logic             out_ready;
  logic             timeout;

  int tests_run    = 0;
  int tests_failed = 0;

  rr_packet_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_STALL(MS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_src(out_src), .out_ready(out_ready),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b1;
    #3;
    tests_run++;
    if ({grant, out_valid, out_data, out_last, out_src, timeout, req_ready} !== 17'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got grant=%b ov=%b od=%b ol=%b src=%0d to=%b rdy=%b want all 0",
               grant, out_valid, out_data, out_last, out_src, timeout, req_ready);
    end
    do_reset();
  endtask

  task automatic test_single_packet();
    do_reset();
    req_valid = 4'b0001; req_data[1:0] = 2'd1; req_last = '0;
    step();
    tests_run++;
    if (grant !== 4'b0001 || req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL single_grant: got grant=%b ready=%b want 0001/0001", grant, req_ready);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 2'd1 || out_src !== 2'd0 || out_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_word1: got v=%b d=%0d src=%0d l=%b want 1/1/0/0", out_valid, out_data, out_src, out_last);
    end
    req_data[1:0] = 2'd2;
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 2'd2 || out_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_word2: got v=%b d=%0d l=%b want 1/2/0", out_valid, out_data, out_last);
    end
    req_data[1:0] = 2'd3; req_last = 4'b0001;
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 2'd3 || out_last !== 1'b1 || grant !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_word3: got v=%b d=%0d l=%b grant=%b want 1/3/1/0000", out_valid, out_data, out_last, grant);
    end
    req_valid = '0; req_last = '0;
    step();
    tests_run++;
    if (out_valid !== 1'b0 || grant !== 4'b0000) begin
      tests_failed++;
      $display("FAIL single_idle: got v=%b grant=%b want 0/0000", out_valid, grant);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req_valid = 4'b1111; req_last = '0;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(i);
    step();
    for (int p = 0; p < 5; p++) begin
      tests_run++;
      if (grant !== 4'(1 << order[p])) begin
        tests_failed++;
        $display("FAIL rr_grant pkt%0d: got %b want %b", p, grant, 4'(1 << order[p]));
      end
      req_last = '0;
      step();
      tests_run++;
      if (out_valid !== 1'b1 || out_src !== 2'(order[p]) || out_data !== 2'(order[p]) || out_last !== 1'b0) begin
        tests_failed++;
        $display("FAIL rr_word1 pkt%0d: got v=%b src=%0d d=%0d l=%b want 1/%0d/%0d/0",
                 p, out_valid, out_src, out_data, out_last, order[p], order[p]);
      end
      req_last = 4'b1111;
      step();
      tests_run++;
      if (out_last !== 1'b1 || out_src !== 2'(order[p]) || grant !== 4'b0000) begin
        tests_failed++;
        $display("FAIL rr_bubble pkt%0d: got l=%b src=%0d grant=%b want 1/%0d/0000",
                 p, out_last, out_src, grant, order[p]);
      end
      req_last = '0;
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0001; req_data[1:0] = 2'd1; req_last = '0; out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0; req_data[1:0] = 2'd2;
    #1;
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL bp_ready_low: got %b want 0000", req_ready);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 2'd1 || req_ready !== 4'b0000) begin
        tests_failed++;
        $display("FAIL bp_hold cyc%0d: got v=%b d=%0d rdy=%b want 1/1/0000", c, out_valid, out_data, req_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL bp_ready_back: got %b want 0001", req_ready);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 2'd2) begin
      tests_failed++;
      $display("FAIL bp_word2: got v=%b d=%0d want 1/2", out_valid, out_data);
    end
    req_data[1:0] = 2'd3; req_last = 4'b0001;
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 2'd3 || out_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_word3: got v=%b d=%0d l=%b want 1/3/1", out_valid, out_data, out_last);
    end
    req_valid = '0; req_last = '0;
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_timeout();
    int early_bad = 0;
    do_reset();
    req_valid = 4'b1100; req_data[5:4] = 2'd2; req_data[7:6] = 2'd3; req_last = '0;
    step();
    tests_run++;
    if (grant !== 4'b0100) begin
      tests_failed++;
      $display("FAIL to_grant2: got %b want 0100", grant);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 2'd2) begin
      tests_failed++;
      $display("FAIL to_word1: got v=%b src=%0d d=%0d want 1/2/2", out_valid, out_src, out_data);
    end
    req_valid = 4'b1000;
    for (int k = 1; k < MS; k++) begin
      step();
      if (timeout !== 1'b0 || grant !== 4'b0100) early_bad++;
    end
    tests_run++;
    if (early_bad != 0) begin
      tests_failed++;
      $display("FAIL to_early: got %0d bad stall cycles want 0", early_bad);
    end
    step();
    tests_run++;
    if (timeout !== 1'b1 || grant !== 4'b0000 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_pulse: got to=%b grant=%b v=%b want 1/0000/0", timeout, grant, out_valid);
    end
    step();
    tests_run++;
    if (timeout !== 1'b0 || grant !== 4'b1000) begin
      tests_failed++;
      $display("FAIL to_next_owner: got to=%b grant=%b want 0/1000", timeout, grant);
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    req_valid = 4'b0001; req_data = '0; req_last = 4'b0001;
    step();
    step();
    req_valid = 4'b0011; req_last = '0; req_data[1:0] = 2'd1; req_data[3:2] = 2'd2;
    step();
    tests_run++;
    if (grant !== 4'b0010) begin
      tests_failed++;
      $display("FAIL rst_pre_grant1: got %b want 0010", grant);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 2'd2) begin
      tests_failed++;
      $display("FAIL rst_pre_word: got v=%b src=%0d d=%0d want 1/1/2", out_valid, out_src, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({grant, out_valid, out_data, out_last, out_src, timeout, req_ready} !== 17'd0) begin
      tests_failed++;
      $display("FAIL rst_async: got grant=%b ov=%b od=%b ol=%b src=%0d to=%b rdy=%b want all 0",
               grant, out_valid, out_data, out_last, out_src, timeout, req_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    tests_run++;
    if (grant !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rst_ptr_zero: got %b want 0001", grant);
    end
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_valid = 4'b0011; req_last = '0; req_data[1:0] = 2'd0; req_data[3:2] = 2'd3;
    step();
    tests_run++;
    if (grant !== 4'b0001) begin
      tests_failed++;
      $display("FAIL b2b_grant: got %b want 0001", grant);
    end
    for (int w = 0; w < 4; w++) begin
      req_data[1:0] = DW'(w);
      req_last      = (w == 3) ? 4'b0001 : 4'b0000;
      #1;
      tests_run++;
      if (req_ready !== 4'b0001) begin
        tests_failed++;
        $display("FAIL b2b_ready w%0d: got %b want 0001", w, req_ready);
      end
      step();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== DW'(w) || out_src !== 2'd0) begin
        tests_failed++;
        $display("FAIL b2b_word w%0d: got v=%b d=%0d src=%0d want 1/%0d/0", w, out_valid, out_data, out_src, w);
      end
    end
    req_last = '0;
    tests_run++;
    if (grant !== 4'b0000 || out_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_end: got grant=%b l=%b want 0000/1", grant, out_last);
    end
    step();
    tests_run++;
    if (grant !== 4'b0010) begin
      tests_failed++;
      $display("FAIL b2b_next: got %b want 0010", grant);
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid_packet();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
